cbx_param_dbuf: RTL and testbench

CBX_PARAM_DBUF -- requirements
Module: cbx_param_dbuf

---
 rtl/cbx_param_dbuf.sv | 128 ++++++++++++
 tb/tb_cbx_param_dbuf.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cbx_param_dbuf.sv
// Connection box with a double-buffered configuration chain.
// A serial shift chain is loaded bit by bit and then committed into a shadow register.
// The input-pin muxes only ever read the shadow register, so their outputs do not move
// while a new configuration is being shifted in.
module cbx_param_dbuf #(
  parameter int unsigned CHAN_WIDTH = 30,
  parameter int unsigned NUM_IPIN   = 4,
  parameter int unsigned MUX_SIZE   = 12,
  parameter int unsigned STRIDE     = 3
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic [CHAN_WIDTH-1:0] chanx_left_in,
  input  logic [CHAN_WIDTH-1:0] chanx_right_in,
  input  logic                  ccff_head,
  input  logic                  ccff_en,
  input  logic                  cfg_commit,
  output logic [CHAN_WIDTH-1:0] chanx_left_out,
  output logic [CHAN_WIDTH-1:0] chanx_right_out,
  output logic [NUM_IPIN-1:0]   ipin_out,
  output logic                  ccff_tail,
  output logic                  cfg_full,
  output logic                  cfg_valid,
  output logic                  cfg_err
);

  localparam int unsigned SEL_BITS  = $clog2(MUX_SIZE);
  localparam int unsigned L         = NUM_IPIN * SEL_BITS;
  localparam int unsigned CNT_W     = $clog2(L + 1);
  localparam int unsigned NUM_PAIRS = MUX_SIZE / 2;

  // Elaboration-time parameter sanity checks.
  if (CHAN_WIDTH < 2) begin : g_bad_chan
    $error("CHAN_WIDTH must be >= 2");
  end
  if ((MUX_SIZE < 2) || (MUX_SIZE % 2 != 0)) begin : g_bad_mux
    $error("MUX_SIZE must be even and >= 2");
  end
  if (L < 2) begin : g_bad_chain
    $error("configuration chain must be at least 2 bits long");
  end

  logic [L-1:0]     chain_q,  chain_d;
  logic [L-1:0]     shadow_q, shadow_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             tail_q,   tail_d;
  logic             valid_q,  valid_d;
  logic             err_q,    err_d;
  logic             full;
  logic             commit_ok;

  // Routing tracks straight across the box.
  assign chanx_right_out = chanx_left_in;
  assign chanx_left_out  = chanx_right_in;

  assign full      = (count_q == CNT_W'(L));
  assign commit_ok = cfg_commit & full;

  assign ccff_tail = tail_q;
  assign cfg_full  = full;
  assign cfg_valid = valid_q;
  assign cfg_err   = err_q;

  // Next-state for the shift chain, bit counter and shadow/status flags.
  always_comb begin
    chain_d  = chain_q;
    shadow_d = shadow_q;
    count_d  = count_q;
    tail_d   = tail_q;
    valid_d  = valid_q;
    err_d    = err_q;

    if (ccff_en) begin
      chain_d = {chain_q[L-2:0], ccff_head};
      tail_d  = chain_q[L-1];
      if (!full) begin
        count_d = count_q + CNT_W'(1);
      end
    end

    if (commit_ok) begin
      // Shadow captures the pre-shift chain; a simultaneous shift restarts the count at 1.
      shadow_d = chain_q;
      valid_d  = 1'b1;
      count_d  = ccff_en ? CNT_W'(1) : '0;
    end else if (cfg_commit) begin
      err_d = 1'b1;
    end
  end

  // State registers with synchronous reset that overrides shift and commit.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      chain_q  <= '0;
      shadow_q <= '0;
      count_q  <= '0;
      tail_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      chain_q  <= chain_d;
      shadow_q <= shadow_d;
      count_q  <= count_d;
      tail_q   <= tail_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  // Input-pin muxes: pair k of mux j taps track (j + k*STRIDE) mod CHAN_WIDTH,
  // even inputs from the left side, odd inputs from the right side.
  for (genvar j = 0; j < NUM_IPIN; j++) begin : g_ipin
    logic [MUX_SIZE-1:0] mux_in;
    logic [SEL_BITS-1:0] sel;

    for (genvar k = 0; k < NUM_PAIRS; k++) begin : g_pair
      localparam int unsigned Trk = (j + k * STRIDE) % CHAN_WIDTH;
      assign mux_in[2*k]   = chanx_left_in[Trk];
      assign mux_in[2*k+1] = chanx_right_in[Trk];
    end

    assign sel = shadow_q[j*SEL_BITS +: SEL_BITS];

    // Out-of-range selects and an uncommitted shadow both force the pin low.
    assign ipin_out[j] = (valid_q && (32'(sel) < MUX_SIZE)) ? mux_in[sel] : 1'b0;
  end

endmodule

// File: tb/tb_cbx_param_dbuf.sv
// Self-checking bench for cbx_param_dbuf with default parameters.
module tb_cbx_param_dbuf;

  localparam int CW = 30;
  localparam int NI = 4;
  localparam int MS = 12;
  localparam int ST = 3;
  localparam int SB = 4;
  localparam int L  = NI * SB;

  logic          prog_clk = 1'b0;
  logic          pReset;
  logic [CW-1:0] chanx_left_in, chanx_right_in;
  logic          ccff_head, ccff_en, cfg_commit;
  logic [CW-1:0] chanx_left_out, chanx_right_out;
  logic [NI-1:0] ipin_out;
  logic          ccff_tail, cfg_full, cfg_valid, cfg_err;

  int checks = 0;
  int errors = 0;

  always #5 prog_clk = ~prog_clk;

  cbx_param_dbuf dut (
    .prog_clk       (prog_clk),
    .pReset         (pReset),
    .chanx_left_in  (chanx_left_in),
    .chanx_right_in (chanx_right_in),
    .ccff_head      (ccff_head),
    .ccff_en        (ccff_en),
    .cfg_commit     (cfg_commit),
    .chanx_left_out (chanx_left_out),
    .chanx_right_out(chanx_right_out),
    .ipin_out       (ipin_out),
    .ccff_tail      (ccff_tail),
    .cfg_full       (cfg_full),
    .cfg_valid      (cfg_valid),
    .cfg_err        (cfg_err)
  );

  // Reference model: history of shifted bits, bit count, committed config and flags.
  bit           hist[$];
  int           m_count;
  logic [L-1:0] m_shadow;
  bit           m_valid, m_err, m_tail;

  function automatic logic [L-1:0] chain_vec();
    logic [L-1:0] v = '0;
    for (int i = 0; i < L; i++)
      if (i < hist.size()) v[i] = hist[hist.size() - 1 - i];
    return v;
  endfunction

  function automatic logic [NI-1:0] m_ipin();
    logic [NI-1:0] r = '0;
    for (int j = 0; j < NI; j++) begin
      int sel = int'(m_shadow[j*SB +: SB]);
      if (m_valid && sel < MS) begin
        int t = (j + (sel / 2) * ST) % CW;
        r[j] = (sel % 2 == 1) ? chanx_right_in[t] : chanx_left_in[t];
      end
    end
    return r;
  endfunction

  task automatic model_update(input bit en, input bit head, input bit commit, input bit rst);
    if (rst) begin
      hist.delete();
      m_count = 0; m_shadow = '0; m_valid = 0; m_err = 0; m_tail = 0;
    end else begin
      bit was_full = (m_count == L);
      if (commit && was_full) begin
        m_shadow = chain_vec();
        m_valid  = 1;
        m_count  = 0;
      end else if (commit) begin
        m_err = 1;
      end
      if (en) begin
        m_tail = (hist.size() == L) ? hist[0] : 1'b0;
        hist.push_back(head);
        if (hist.size() > L) void'(hist.pop_front());
        if (m_count < L) m_count++;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ipin"},  32'(ipin_out),        32'(m_ipin()));
    chk({tag, ".tail"},  32'(ccff_tail),       32'(m_tail));
    chk({tag, ".full"},  32'(cfg_full),        32'(m_count == L));
    chk({tag, ".valid"}, 32'(cfg_valid),       32'(m_valid));
    chk({tag, ".err"},   32'(cfg_err),         32'(m_err));
    chk({tag, ".lout"},  32'(chanx_left_out),  32'(chanx_right_in));
    chk({tag, ".rout"},  32'(chanx_right_out), 32'(chanx_left_in));
  endtask

  task automatic cycle(input bit en, input bit head, input bit commit, input bit rst,
                       input string tag);
    ccff_en = en; ccff_head = head; cfg_commit = commit; pReset = rst;
    @(posedge prog_clk);
    model_update(en, head, commit, rst);
    #1;
    check_all(tag);
  endtask

  // Shift the low nbits of word in MSB first.
  task automatic shift_word(input logic [31:0] word, input int nbits, input string tag);
    for (int i = nbits - 1; i >= 0; i--) cycle(1'b1, word[i], 1'b0, 1'b0, tag);
  endtask

  typedef struct {
    logic [CW-1:0] left;
    logic [CW-1:0] right;
    logic [NI-1:0] exp;
  } vec_t;

  vec_t tbl[7];

  // Config 0x3210 selects left[0], right[1], left[5], right[6] on pins 0..3.
  task automatic run_table(input string tag);
    shift_word(32'h3210, 16, tag);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, tag);
    chk({tag, ".valid_hi"}, 32'(cfg_valid), 32'd1);
    for (int i = 0; i < 7; i++) begin
      chanx_left_in  = tbl[i].left;
      chanx_right_in = tbl[i].right;
      #1;
      chk($sformatf("%s.vec%0d", tag, i), 32'(ipin_out), 32'(tbl[i].exp));
      chk($sformatf("%s.vec%0d.pass", tag, i), 32'(chanx_right_out), 32'(tbl[i].left));
    end
  endtask

  initial begin
    logic [NI-1:0] saved;
    tbl[0] = '{left: '1, right: '0, exp: 4'b0101};
    tbl[1] = '{left: '0, right: '1, exp: 4'b1010};
    tbl[2] = '{left: 30'(1) << 5, right: '0, exp: 4'b0100};
    tbl[3] = '{left: '0, right: 30'(1) << 6, exp: 4'b1000};
    tbl[4] = '{left: 30'(1), right: 30'(1) << 1, exp: 4'b0011};
    tbl[5] = '{left: ~30'(33), right: ~30'(66), exp: 4'b0000};
    tbl[6] = '{left: 30'(66), right: 30'(33), exp: 4'b0000};

    chanx_left_in = '0; chanx_right_in = '0;
    ccff_head = 0; ccff_en = 0; cfg_commit = 0; pReset = 1;

    // Reset overrides shift and commit requests.
    cycle(1'b1, 1'b1, 1'b1, 1'b1, "rst0");
    cycle(1'b0, 1'b0, 0, 1'b1, "rst1");
    chk("rst.ipin", 32'(ipin_out), 32'd0);
    chk("rst.valid", 32'(cfg_valid), 32'd0);

    run_table("load1");

    // Early commit flags an error and leaves the shadow untouched.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, "rst2");
    shift_word(32'h3210, 10, "early");
    cycle(1'b0, 1'b0, 1'b1, 1'b0, "early_commit");
    chk("early.err", 32'(cfg_err), 32'd1);
    chk("early.valid", 32'(cfg_valid), 32'd0);
    chk("early.ipin", 32'(ipin_out), 32'd0);
    shift_word(32'h3210, 6, "rest");
    cycle(1'b0, 1'b0, 1'b1, 1'b0, "late_commit");
    chk("late.valid", 32'(cfg_valid), 32'd1);
    chk("late.err_sticky", 32'(cfg_err), 32'd1);

    // Shifting a new config must not disturb the active one.
    chanx_left_in = CW'($urandom); chanx_right_in = CW'($urandom);
    #1;
    saved = ipin_out;
    for (int i = 15; i >= 0; i--) begin
      logic [31:0] w = 32'h0123;
      cycle(1'b1, w[i], 1'b0, 1'b0, "reload");
      chk("reload.hold", 32'(ipin_out), 32'(saved));
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, "reload_commit");

    // Out-of-range select on pin 0 always drives 0.
    for (int s = 12; s < 16; s++) begin
      shift_word(32'h3210 | 32'(s), 16, "oor");
      cycle(1'b0, 1'b0, 1'b1, 1'b0, "oor_commit");
      for (int r = 0; r < 4; r++) begin
        chanx_left_in = CW'($urandom); chanx_right_in = CW'($urandom);
        #1;
        chk($sformatf("oor%0d.ipin0", s), 32'(ipin_out[0]), 32'd0);
      end
    end

    // Commit and shift on the same edge.
    shift_word(32'hA5C3, 16, "cs_load");
    cycle(1'b1, 1'b0, 1'b1, 1'b0, "cs");
    chk("cs.full", 32'(cfg_full), 32'd0);
    chk("cs.tail", 32'(ccff_tail), 32'd1);
    shift_word(32'h0, 14, "cs_more");
    chk("cs.full_at15", 32'(cfg_full), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, "cs_last");
    chk("cs.full_at16", 32'(cfg_full), 32'd1);

    // Reset in the middle of a load.
    shift_word(32'h00FF, 8, "mid");
    cycle(1'b1, 1'b1, 1'b1, 1'b1, "mid_rst");
    chk("mid.ipin", 32'(ipin_out), 32'd0);
    chk("mid.err", 32'(cfg_err), 32'd0);
    chk("mid.valid", 32'(cfg_valid), 32'd0);
    run_table("load2");

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      chanx_left_in  = CW'($urandom);
      chanx_right_in = CW'($urandom);
      cycle(($urandom % 8) != 0, 1'($urandom), ($urandom % 14) == 0,
            ($urandom % 300) == 0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
